conv_row_scheduler: RTL and testbench

Sequences the three-bank line-buffer/slab BRAM router for one 3x3 convolution pass over a feature-map tile. For each output row it issues the top/middle/bottom image-row addresses and bank indices word by word, with the left-neighbour slab addresses and zero-padding at tile edges. One cycle later it presents the matching registered "last" indices and a data-valid strobe, so the router's bank read data can be steered back. It sits between the layer controller (start/done) and the BRAM router, and honours a downstream ready.

---
 rtl/conv_row_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_conv_row_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_scheduler.sv
// Row/word sequencer for a 3x3 convolution pass over a line-buffer tile.
// Issues top/mid/bottom bank addresses and then presents the registered "last" indices.
module conv_row_scheduler #(
    parameter int ROW_WORDS = 4,
    parameter int NUM_ROWS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] row1_buf_adr,
    output logic [15:0] row2_buf_adr,
    output logic [15:0] row3_buf_adr,
    output logic [1:0]  row1_buf_idx,
    output logic [1:0]  row2_buf_idx,
    output logic [1:0]  row3_buf_idx,
    output logic [15:0] row1_slab_adr,
    output logic [15:0] row2_slab_adr,
    output logic [15:0] row3_slab_adr,
    output logic [1:0]  row1_slab_idx,
    output logic [1:0]  row2_slab_idx,
    output logic [1:0]  row3_slab_idx,
    output logic        valid_row1_adr,
    output logic        valid_row2_adr,
    output logic        valid_row3_adr,
    output logic [1:0]  last_row1_buf_idx,
    output logic [1:0]  last_row2_buf_idx,
    output logic [1:0]  last_row3_buf_idx,
    output logic [1:0]  last_row1_slab_idx,
    output logic [1:0]  last_row2_slab_idx,
    output logic [1:0]  last_row3_slab_idx,
    output logic        data_valid,
    output logic [7:0]  out_row,
    output logic [7:0]  out_word
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam logic [7:0]  W_LAST   = 8'(ROW_WORDS - 1);
    localparam logic [7:0]  R_LAST   = 8'(NUM_ROWS - 1);
    localparam logic [15:0] ROW_STEP = 16'(ROW_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  r_q, r_d;
    logic [1:0]  bank_prev_q, bank_prev_d;
    logic [1:0]  bank_cur_q, bank_cur_d;
    logic [1:0]  bank_next_q, bank_next_d;
    logic [15:0] base_prev_q, base_prev_d;
    logic [15:0] base_cur_q, base_cur_d;
    logic [15:0] base_next_q, base_next_d;

    logic [2:0][1:0] last_buf_q, last_buf_d;
    logic [2:0][1:0] last_slab_q, last_slab_d;
    logic            dv_q, dv_d;
    logic [7:0]      out_row_q, out_row_d;
    logic [7:0]      out_word_q, out_word_d;

    logic            issue;
    logic [2:0]      row_ok;
    logic [2:0][1:0] bank;
    logic [2:0][15:0] base;
    logic [2:0][1:0]  buf_idx;
    logic [2:0][15:0] buf_adr;
    logic [2:0][1:0]  slab_idx;
    logic [2:0][15:0] slab_adr;
    logic [2:0]       row_vld;

    // Index 0 = top (r-1), 1 = mid (r), 2 = bottom (r+1)
    always_comb begin
        issue     = (state_q == S_RUN) && ready;
        row_ok[0] = (r_q != 8'd0);
        row_ok[1] = 1'b1;
        row_ok[2] = (r_q != R_LAST);
        bank      = {bank_next_q, bank_cur_q, bank_prev_q};
        base      = {base_next_q, base_cur_q, base_prev_q};
        for (int i = 0; i < 3; i++) begin
            buf_idx[i]  = 2'd0;
            buf_adr[i]  = 16'd0;
            slab_idx[i] = 2'd0;
            slab_adr[i] = 16'd0;
            row_vld[i]  = 1'b0;
            if (issue && row_ok[i]) begin
                row_vld[i] = 1'b1;
                buf_idx[i] = bank[i];
                buf_adr[i] = base[i] + {8'd0, w_q};
                if (w_q != 8'd0) begin
                    slab_idx[i] = bank[i];
                    slab_adr[i] = buf_adr[i] - 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        r_d         = r_q;
        bank_prev_d = bank_prev_q;
        bank_cur_d  = bank_cur_q;
        bank_next_d = bank_next_q;
        base_prev_d = base_prev_q;
        base_cur_d  = base_cur_q;
        base_next_d = base_next_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    w_d         = 8'd0;
                    r_d         = 8'd0;
                    // Virtual row -1 sits in bank 3 one row-block below 0
                    bank_prev_d = 2'd3;
                    bank_cur_d  = 2'd1;
                    bank_next_d = 2'd2;
                    base_prev_d = 16'd0 - ROW_STEP;
                    base_cur_d  = 16'd0;
                    base_next_d = 16'd0;
                end
            end
            S_RUN: begin
                if (ready) begin
                    if (w_q == W_LAST) begin
                        w_d         = 8'd0;
                        r_d         = r_q + 8'd1;
                        bank_prev_d = bank_cur_q;
                        bank_cur_d  = bank_next_q;
                        bank_next_d = bank_prev_q;
                        base_prev_d = base_cur_q;
                        base_cur_d  = base_next_q;
                        base_next_d = base_prev_q + ROW_STEP;
                        if (r_q == R_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        w_d = w_q + 8'd1;
                    end
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_buf_d  = buf_idx;
        last_slab_d = slab_idx;
        dv_d        = issue;
        out_row_d   = issue ? r_q : out_row_q;
        out_word_d  = issue ? w_q : out_word_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            w_q         <= 8'd0;
            r_q         <= 8'd0;
            bank_prev_q <= 2'd0;
            bank_cur_q  <= 2'd0;
            bank_next_q <= 2'd0;
            base_prev_q <= 16'd0;
            base_cur_q  <= 16'd0;
            base_next_q <= 16'd0;
            last_buf_q  <= '0;
            last_slab_q <= '0;
            dv_q        <= 1'b0;
            out_row_q   <= 8'd0;
            out_word_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            r_q         <= r_d;
            bank_prev_q <= bank_prev_d;
            bank_cur_q  <= bank_cur_d;
            bank_next_q <= bank_next_d;
            base_prev_q <= base_prev_d;
            base_cur_q  <= base_cur_d;
            base_next_q <= base_next_d;
            last_buf_q  <= last_buf_d;
            last_slab_q <= last_slab_d;
            dv_q        <= dv_d;
            out_row_q   <= out_row_d;
            out_word_q  <= out_word_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DRAIN);

    assign row1_buf_adr   = buf_adr[0];
    assign row2_buf_adr   = buf_adr[1];
    assign row3_buf_adr   = buf_adr[2];
    assign row1_buf_idx   = buf_idx[0];
    assign row2_buf_idx   = buf_idx[1];
    assign row3_buf_idx   = buf_idx[2];
    assign row1_slab_adr  = slab_adr[0];
    assign row2_slab_adr  = slab_adr[1];
    assign row3_slab_adr  = slab_adr[2];
    assign row1_slab_idx  = slab_idx[0];
    assign row2_slab_idx  = slab_idx[1];
    assign row3_slab_idx  = slab_idx[2];
    assign valid_row1_adr = row_vld[0];
    assign valid_row2_adr = row_vld[1];
    assign valid_row3_adr = row_vld[2];

    assign last_row1_buf_idx  = last_buf_q[0];
    assign last_row2_buf_idx  = last_buf_q[1];
    assign last_row3_buf_idx  = last_buf_q[2];
    assign last_row1_slab_idx = last_slab_q[0];
    assign last_row2_slab_idx = last_slab_q[1];
    assign last_row3_slab_idx = last_slab_q[2];
    assign data_valid         = dv_q;
    assign out_row            = out_row_q;
    assign out_word           = out_word_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Randomized bench for conv_row_scheduler against a row/word arithmetic model.
module tb_conv_row_scheduler;

    localparam int RW = 4;
    localparam int NR = 5;

    logic        clk, reset, start, ready;
    logic        busy, done;
    logic [15:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
    logic [1:0]  row1_buf_idx, row2_buf_idx, row3_buf_idx;
    logic [15:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
    logic [1:0]  row1_slab_idx, row2_slab_idx, row3_slab_idx;
    logic        valid_row1_adr, valid_row2_adr, valid_row3_adr;
    logic [1:0]  last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
    logic [1:0]  last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
    logic        data_valid;
    logic [7:0]  out_row, out_word;

    int pass_cnt = 0;
    int total_cnt = 0;

    conv_row_scheduler #(.ROW_WORDS(RW), .NUM_ROWS(NR)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .busy(busy), .done(done),
        .row1_buf_adr(row1_buf_adr), .row2_buf_adr(row2_buf_adr),
        .row3_buf_adr(row3_buf_adr),
        .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx),
        .row3_buf_idx(row3_buf_idx),
        .row1_slab_adr(row1_slab_adr), .row2_slab_adr(row2_slab_adr),
        .row3_slab_adr(row3_slab_adr),
        .row1_slab_idx(row1_slab_idx), .row2_slab_idx(row2_slab_idx),
        .row3_slab_idx(row3_slab_idx),
        .valid_row1_adr(valid_row1_adr), .valid_row2_adr(valid_row2_adr),
        .valid_row3_adr(valid_row3_adr),
        .last_row1_buf_idx(last_row1_buf_idx),
        .last_row2_buf_idx(last_row2_buf_idx),
        .last_row3_buf_idx(last_row3_buf_idx),
        .last_row1_slab_idx(last_row1_slab_idx),
        .last_row2_slab_idx(last_row2_slab_idx),
        .last_row3_slab_idx(last_row3_slab_idx),
        .data_valid(data_valid), .out_row(out_row), .out_word(out_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [110:0] got_issue();
        return {row1_buf_adr, row2_buf_adr, row3_buf_adr,
                row1_buf_idx, row2_buf_idx, row3_buf_idx,
                row1_slab_adr, row2_slab_adr, row3_slab_adr,
                row1_slab_idx, row2_slab_idx, row3_slab_idx,
                valid_row1_adr, valid_row2_adr, valid_row3_adr};
    endfunction

    function automatic logic [11:0] got_last();
        return {last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
                last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, done, data_valid} !== 3'b000) begin
            $display("FAIL reset_status got %b exp 000", {busy, done, data_valid});
        end else pass_cnt++;
        total_cnt++;
        if ({got_issue(), got_last(), out_row, out_word} !== '0) begin
            $display("FAIL reset_outputs got %h exp 0",
                     {got_issue(), got_last(), out_row, out_word});
        end else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_directed_pass();
        @(posedge clk); #1 start = 1'b1; ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total_cnt++;
                if ({busy, row1_buf_idx, row2_buf_idx, row2_buf_adr,
                     row3_buf_idx, row3_buf_adr} !== {1'b1, 2'd0, 2'd1, 16'd0, 2'd2, 16'd0}) begin
                    $display("FAIL top_edge got %h", {busy, row1_buf_idx, row2_buf_idx,
                             row2_buf_adr, row3_buf_idx, row3_buf_adr});
                end else pass_cnt++;
                total_cnt++;
                if ({row1_slab_idx, row2_slab_idx, row3_slab_idx} !== 6'd0) begin
                    $display("FAIL top_slab got %h exp 0",
                             {row1_slab_idx, row2_slab_idx, row3_slab_idx});
                end else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++;
                if ({last_row2_buf_idx, data_valid, out_row, out_word} !==
                    {2'd1, 1'b1, 8'd0, 8'd0}) begin
                    $display("FAIL top_last got %h exp 1 1 0 0",
                             {last_row2_buf_idx, data_valid, out_row, out_word});
                end else pass_cnt++;
            end
            if (c == 14) begin
                total_cnt++;
                if ({row1_buf_idx, row2_buf_idx, row3_buf_idx,
                     row1_buf_adr, row2_buf_adr, row3_buf_adr} !==
                    {2'd3, 2'd1, 2'd2, 16'd1, 16'd5, 16'd5}) begin
                    $display("FAIL rot_buf got %h", {row1_buf_idx, row2_buf_idx,
                             row3_buf_idx, row1_buf_adr, row2_buf_adr, row3_buf_adr});
                end else pass_cnt++;
                total_cnt++;
                if ({row1_slab_idx, row2_slab_idx, row3_slab_idx,
                     row1_slab_adr, row2_slab_adr, row3_slab_adr} !==
                    {2'd3, 2'd1, 2'd2, 16'd0, 16'd4, 16'd4}) begin
                    $display("FAIL rot_slab got %h", {row1_slab_idx, row2_slab_idx,
                             row3_slab_idx, row1_slab_adr, row2_slab_adr, row3_slab_adr});
                end else pass_cnt++;
            end
            if (c == 20) begin
                total_cnt++;
                if ({row3_buf_idx, valid_row3_adr, row1_buf_idx, row1_buf_adr,
                     row2_buf_idx, row2_buf_adr} !==
                    {2'd0, 1'b0, 2'd1, 16'd7, 2'd2, 16'd7}) begin
                    $display("FAIL bottom_edge got %h", {row3_buf_idx, valid_row3_adr,
                             row1_buf_idx, row1_buf_adr, row2_buf_idx, row2_buf_adr});
                end else pass_cnt++;
            end
            if (c == 21) begin
                total_cnt++;
                if ({busy, done, data_valid} !== 3'b111) begin
                    $display("FAIL drain_status got %b exp 111", {busy, done, data_valid});
                end else pass_cnt++;
            end
            if (c == 22) begin
                total_cnt++;
                if ({busy, done, data_valid} !== 3'b000) begin
                    $display("FAIL idle_after got %b exp 000", {busy, done, data_valid});
                end else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Model: row k in bank k%3+1 at (k/3)*RW + w; random ready and stray starts
    task automatic test_full_pass(input int stall_pct, input int stall_at,
                                  input int stall_len, input string tag);
        int r, w, cyc, issued, stalled, nstall;
        bit rdy, iss, prev_iss, running;
        int prev_r, prev_w;
        logic [1:0]  eb_idx[3], es_idx[3], pb_idx[3], ps_idx[3];
        logic [15:0] eb_adr[3], es_adr[3];
        logic        e_vld[3];
        logic [110:0] exp_iss;
        logic [11:0]  exp_last;
        r = 0; w = 0; cyc = 0; issued = 0; stalled = 0; nstall = 0;
        prev_iss = 1'b0; prev_r = 0; prev_w = 0;
        for (int i = 0; i < 3; i++) begin pb_idx[i] = 2'd0; ps_idx[i] = 2'd0; end
        @(posedge clk); #1 start = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        while (1) begin
            running = (r < NR);
            rdy = ($urandom_range(99) >= stall_pct);
            if (issued == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            iss = running && rdy;
            ready = rdy;
            start = running ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int row;
                row = r - 1 + i;
                eb_idx[i] = 2'd0; eb_adr[i] = 16'd0; e_vld[i] = 1'b0;
                es_idx[i] = 2'd0; es_adr[i] = 16'd0;
                if (iss && row >= 0 && row < NR) begin
                    eb_idx[i] = 2'(row % 3 + 1);
                    eb_adr[i] = 16'((row / 3) * RW + w);
                    e_vld[i]  = 1'b1;
                    if (w > 0) begin
                        es_idx[i] = eb_idx[i];
                        es_adr[i] = eb_adr[i] - 16'd1;
                    end
                end
            end
            exp_iss = {eb_adr[0], eb_adr[1], eb_adr[2], eb_idx[0], eb_idx[1], eb_idx[2],
                       es_adr[0], es_adr[1], es_adr[2], es_idx[0], es_idx[1], es_idx[2],
                       e_vld[0], e_vld[1], e_vld[2]};
            exp_last = {pb_idx[0], pb_idx[1], pb_idx[2], ps_idx[0], ps_idx[1], ps_idx[2]};
            total_cnt++;
            if ({busy, done, data_valid} !== {1'b1, !running, prev_iss}) begin
                $display("FAIL %s status r=%0d w=%0d got %b exp %b", tag, r, w,
                         {busy, done, data_valid}, {1'b1, !running, prev_iss});
            end else pass_cnt++;
            total_cnt++;
            if (got_issue() !== exp_iss) begin
                $display("FAIL %s issue r=%0d w=%0d got %h exp %h", tag, r, w,
                         got_issue(), exp_iss);
            end else pass_cnt++;
            total_cnt++;
            if (got_last() !== exp_last) begin
                $display("FAIL %s last r=%0d w=%0d got %h exp %h", tag, r, w,
                         got_last(), exp_last);
            end else pass_cnt++;
            if (prev_iss) begin
                total_cnt++;
                if ({out_row, out_word} !== {8'(prev_r), 8'(prev_w)}) begin
                    $display("FAIL %s out_pos got %0d,%0d exp %0d,%0d", tag,
                             out_row, out_word, prev_r, prev_w);
                end else pass_cnt++;
            end
            if (!running) begin
                total_cnt++;
                if (cyc !== NR * RW + nstall) begin
                    $display("FAIL %s drain_cycle got %0d exp %0d", tag, cyc, NR * RW + nstall);
                end else pass_cnt++;
                break;
            end
            if (running && !rdy) nstall++;
            prev_iss = iss; prev_r = r; prev_w = w;
            for (int i = 0; i < 3; i++) begin pb_idx[i] = eb_idx[i]; ps_idx[i] = es_idx[i]; end
            if (iss) begin
                issued++;
                if (w == RW - 1) begin w = 0; r++; end
                else w++;
            end
            cyc++;
            if (cyc > 2000) begin
                total_cnt++;
                $display("FAIL %s timeout got %0d cycles exp <= 2000", tag, cyc);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1 start = 1'b0; ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, data_valid, got_issue()} !== '0) begin
            $display("FAIL %s post_idle got %b exp 000", tag, {busy, done, data_valid});
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        test_full_pass(0, -1, 0, "b2b_a");
        test_full_pass(0, -1, 0, "b2b_b");
    endtask

    task automatic test_abort();
        bit saw_done;
        @(posedge clk); #1 start = 1'b1; ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, data_valid} !== 3'b000) begin
            $display("FAIL abort_status got %b exp 000", {busy, done, data_valid});
        end else pass_cnt++;
        total_cnt++;
        if ({got_issue(), got_last(), out_row, out_word} !== '0) begin
            $display("FAIL abort_outputs got %h exp 0",
                     {got_issue(), got_last(), out_row, out_word});
        end else pass_cnt++;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done !== 1'b0) begin
            $display("FAIL abort_no_done got %b exp 0", saw_done);
        end else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ready = 1'b0;
        test_reset();
        test_directed_pass();
        test_full_pass(0, 10, 3, "stall");
        test_full_pass(0, 0, 2, "stall_first");
        test_full_pass(0, NR * RW - 1, 4, "stall_last");
        test_full_pass(30, -1, 0, "random1");
        test_full_pass(50, -1, 0, "random2");
        test_back_to_back();
        test_abort();
        test_full_pass(25, -1, 0, "after_abort");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
